// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the execute stage.
// Produces {remainder, quotient} one quotient bit per cycle. Signed operation
// divides magnitudes and then fixes the signs. Compile-time option
// DIV_ZERO_FAST_EN adds a short path for a zero divisor that returns 0.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StZero} stateT;

  stateT              stateQ, stateD;
  logic [CntW-1:0]    cntQ, cntD;
  logic [2*WIDTH:0]   remQuoQ, remQuoD;
  logic [WIDTH-1:0]   divisorQ, divisorD;
  logic               qNegQ, qNegD;
  logic               rNegQ, rNegD;
  logic [2*WIDTH-1:0] resultD;

  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH:0]   shifted, iterNext;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo, rem, quoFix, remFix;

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    absA = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + One) : opdata1;
    absB = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + One) : opdata2;
  end

  // One restoring step: shift, trial subtract, keep difference if non-negative.
  always_comb begin
    shifted = {remQuoQ[2*WIDTH-1:0], 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisorQ};
    if (trial[WIDTH]) begin
      iterNext = shifted;
    end else begin
      iterNext = {trial, shifted[WIDTH-1:1], 1'b1};
    end
    quo    = iterNext[WIDTH-1:0];
    rem    = iterNext[2*WIDTH-1:WIDTH];
    quoFix = qNegQ ? (~quo + One) : quo;
    remFix = rNegQ ? (~rem + One) : rem;
  end

  // Next-state, datapath and result load; annul overrides everything.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    remQuoD  = remQuoQ;
    divisorD = divisorQ;
    qNegD    = qNegQ;
    rNegD    = rNegQ;
    resultD  = result;
    if (annul) begin
      stateD = StIdle;
      cntD   = '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          cntD = '0;
          if (start) begin
            remQuoD  = {{(WIDTH + 1){1'b0}}, absA};
            divisorD = absB;
            qNegD    = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            rNegD    = signed_div & opdata1[WIDTH-1];
            stateD   = StBusy;
`ifdef DIV_ZERO_FAST_EN
            if (opdata2 == '0) begin
              stateD = StZero;
            end
`endif
          end
        end
        StBusy: begin
          remQuoD = iterNext;
          cntD    = cntQ + CntW'(1);
          if (cntQ == LastIter) begin
            stateD  = StDone;
            cntD    = '0;
            resultD = {remFix, quoFix};
          end
        end
        StDone: begin
          // Requester holds start until it sees ready; leave once it drops.
          if (!start) begin
            stateD = StIdle;
          end
        end
        StZero: begin
`ifdef DIV_ZERO_FAST_EN
          stateD  = StDone;
          resultD = '0;
`else
          stateD  = StIdle;
`endif
        end
        default: stateD = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      remQuoQ  <= '0;
      divisorQ <= '0;
      qNegQ    <= 1'b0;
      rNegQ    <= 1'b0;
      result   <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      remQuoQ  <= remQuoD;
      divisorQ <= divisorD;
      qNegQ    <= qNegD;
      rNegQ    <= rNegD;
      result   <= resultD;
    end
  end

  assign ready = (stateQ == StDone);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed divides plus
// hand-written sequences for hold-after-ready, annul and mid-op reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZeroCyc = 2;
  localparam logic [63:0] ZeroNegRes = 64'h0;
  localparam logic [63:0] ZeroPosRes = 64'h0;
`else
  localparam int ZeroCyc = 33;
  localparam logic [63:0] ZeroNegRes = {32'hFFFFFFFB, 32'h00000001};
  localparam logic [63:0] ZeroPosRes = {32'h00000007, 32'hFFFFFFFF};
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          cyc;
    string       name;
  } vecT;

  localparam int NumVec = 11;
  vecT vecs[NumVec];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .result    (result),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge (cycle 0). Holds start until ready, scrambling the
  // operands after acceptance, then drops start and samples the next cycle.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [63:0] res, output int rdyCyc, output logic lowAfter);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    rdyCyc     = -1;
    res        = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = ~sgn;
      if (ready) begin
        rdyCyc = c;
        res    = result;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lowAfter = ~ready;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] prior;
    int          cyc;
    logic        low;
    logic        sawReady;

    vecs[0]  = '{32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7"};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2"};
    vecs[2]  = '{32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, "div_7_m2"};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "div_ovf"};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 33, "divu_ovf"};
    vecs[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'h0000000E}, 33,
                 "div_m100_m7"};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, "divu_max_1"};
    vecs[7]  = '{32'd5, 32'd10, 1'b0, {32'd5, 32'd0}, 33, "divu_5_10"};
    vecs[8]  = '{32'hFFFFFFFB, 32'd0, 1'b1, ZeroNegRes, ZeroCyc, "div_m5_0"};
    vecs[9]  = '{32'd7, 32'd0, 1'b0, ZeroPosRes, ZeroCyc, "divu_7_0"};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'h0, 32'h1}, 33, "divu_max_max"};

    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    repeat (2) @(negedge clk);
    check64("reset_result", result, 64'h0);
    checkInt("reset_ready", int'(ready), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NumVec; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].sgn, res, cyc, low);
      check64({vecs[i].name, "_result"}, res, vecs[i].exp);
      checkInt({vecs[i].name, "_ready_cycle"}, cyc, vecs[i].cyc);
      checkInt({vecs[i].name, "_idle_after"}, int'(low), 1);
    end

    // start held 3 cycles past ready: ready/result stable for 4 cycles.
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    cyc        = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        cyc = c;
        break;
      end
    end
    checkInt("hold_ready_cycle", cyc, 33);
    for (int k = 0; k < 4; k++) begin
      checkInt($sformatf("hold_ready_%0d", k), int'(ready), 1);
      check64($sformatf("hold_result_%0d", k), result, {32'd2, 32'd14});
      if (k < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkInt("hold_idle_after", int'(ready), 0);

    // Annul in cycle 10 of 1000/3: no ready, result keeps prior value.
    prior      = {32'd2, 32'd14};
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    sawReady   = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) sawReady = 1'b1;
    end
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    if (ready) sawReady = 1'b1;
    checkInt("annul_no_ready", int'(sawReady), 0);
    check64("annul_result_kept", result, prior);
    runOp(32'd9, 32'd3, 1'b0, res, cyc, low);
    check64("after_annul_result", res, {32'd0, 32'd3});
    checkInt("after_annul_ready_cycle", cyc, 33);

    // Reset pulsed mid-BUSY takes effect without a clock edge.
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkInt("midreset_ready", int'(ready), 0);
    check64("midreset_result", result, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp(32'd1000, 32'd3, 1'b0, res, cyc, low);
    check64("post_reset_result", res, {32'd1, 32'd333});
    checkInt("post_reset_ready_cycle", cyc, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
